// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - sync/debounce raw push-buttons into clean controls for the clock/calendar block
// Optional hold-to-repeat on up/down is compiled in when AUTO_REPEAT_EN is defined.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 100000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 10000000,
  parameter int CNT_W           = 28
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_change,
  input  logic btn_reset,
  output logic up,
  output logic down,
  output logic change,
  output logic clear_req,
  output logic any_held
);

  localparam int K_UP   = 0;
  localparam int K_DOWN = 1;
  localparam int K_CHG  = 2;
  localparam int K_RST  = 3;

  localparam logic [CNT_W-1:0] L_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] L_RD_LAST   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] L_RR_LAST   = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_REPEAT} key_state_t;
`else
  typedef enum logic {S_IDLE, S_FIRST} key_state_t;
`endif

  typedef enum logic [1:0] {R_IDLE, R_HOLD, R_DONE} rkey_state_t;

  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES <= DEBOUNCE_CYCLES ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1 || CNT_W < 2) begin : g_param_check
    $error("button_conditioner: illegal parameter set");
  end

  logic [3:0]       w_raw;
  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       w_stable;
  logic [3:0]       w_stable_nxt;
  logic [3:0]       w_done;
  logic [3:0]       w_rise;
  logic [1:0]       w_key_pulse;

  rkey_state_t      r_rstate;
  logic [CNT_W-1:0] r_hcnt;
  logic             r_clear;
  logic             r_change;
  logic             r_any_held;
  logic             w_rst_fall;
  logic             w_clear_fire;
  logic             w_kill;

  assign w_raw = {btn_reset, btn_change, btn_down, btn_up};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: a level change is accepted on the DEBOUNCE_CYCLES-th consecutive differing edge.
  for (genvar g = 0; g < 4; g++) begin : g_db
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;

    assign w_diff          = r_sync2[g] != r_stable;
    assign w_done[g]       = w_diff && (r_cnt == L_DB_LAST);
    assign w_rise[g]       = w_done[g] && !r_stable;
    assign w_stable[g]     = r_stable;
    assign w_stable_nxt[g] = r_stable ^ w_done[g];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_stable <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_stable <= w_stable_nxt[g];
        if (w_diff && !w_done[g]) begin
          r_cnt <= r_cnt + L_ONE;
        end else begin
          r_cnt <= '0;
        end
      end
    end
  end

  assign w_rst_fall   = w_done[K_RST] && w_stable[K_RST];
  assign w_clear_fire = (r_rstate == R_HOLD) && !w_rst_fall && (r_hcnt == L_HOLD_LAST);
  // Once clear fires, up/down stay idle until the reset key is released.
  assign w_kill       = w_clear_fire || (r_rstate == R_DONE);

`ifdef AUTO_REPEAT_EN
  logic w_both_held;
  assign w_both_held = w_stable[K_UP] && w_stable[K_DOWN];
`endif

  for (genvar k = 0; k < 2; k++) begin : g_key
    key_state_t r_state;
    logic       r_pulse;
    logic       w_fall;
`ifdef AUTO_REPEAT_EN
    logic [CNT_W-1:0] r_rcnt;
`endif

    assign w_fall         = w_done[k] && w_stable[k];
    assign w_key_pulse[k] = r_pulse;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_state <= S_IDLE;
        r_pulse <= 1'b0;
`ifdef AUTO_REPEAT_EN
        r_rcnt  <= '0;
`endif
      end else begin
        r_pulse <= 1'b0;
        if (w_kill || w_fall) begin
          r_state <= S_IDLE;
        end else begin
          case (r_state)
            S_IDLE: begin
              if (w_rise[k]) begin
                r_state <= S_FIRST;
                r_pulse <= 1'b1;
`ifdef AUTO_REPEAT_EN
                r_rcnt  <= '0;
`endif
              end
            end
`ifdef AUTO_REPEAT_EN
            S_FIRST: begin
              if (!w_both_held) begin
                if (r_rcnt == L_RD_LAST) begin
                  r_state <= S_REPEAT;
                  r_pulse <= 1'b1;
                  r_rcnt  <= '0;
                end else begin
                  r_rcnt <= r_rcnt + L_ONE;
                end
              end
            end
            S_REPEAT: begin
              if (!w_both_held) begin
                if (r_rcnt == L_RR_LAST) begin
                  r_pulse <= 1'b1;
                  r_rcnt  <= '0;
                end else begin
                  r_rcnt <= r_rcnt + L_ONE;
                end
              end
            end
`endif
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rstate <= R_IDLE;
      r_hcnt   <= '0;
      r_clear  <= 1'b0;
    end else begin
      r_clear <= w_clear_fire;
      case (r_rstate)
        R_IDLE: begin
          if (w_rise[K_RST]) begin
            r_rstate <= R_HOLD;
            r_hcnt   <= '0;
          end
        end
        R_HOLD: begin
          if (w_rst_fall) begin
            r_rstate <= R_IDLE;
          end else if (w_clear_fire) begin
            r_rstate <= R_DONE;
          end else begin
            r_hcnt <= r_hcnt + L_ONE;
          end
        end
        R_DONE: begin
          if (w_rst_fall) begin
            r_rstate <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_change   <= 1'b0;
      r_any_held <= 1'b0;
    end else begin
      r_change   <= r_change ^ (w_rise[K_CHG] && !w_stable[K_RST]);
      r_any_held <= |w_stable_nxt;
    end
  end

  assign up        = w_key_pulse[K_UP];
  assign down      = w_key_pulse[K_DOWN];
  assign change    = r_change;
  assign clear_req = r_clear;
  assign any_held  = r_any_held;

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end conditioning stage directly upstream of the clock/calendar display block.
- Turns the four raw, bouncing push-buttons (up, down, change, reset) into clean control signals for that block:
  - debounced single-cycle pulses for up/down, with optional hold-to-repeat;
  - a debounced toggle level for change (time/date view select);
  - a long-press-qualified clear for reset.
- Everything runs on the board clock, so the downstream block sees glitch-free, synchronous controls.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable clk cycles required to accept a level change; range 2..2^24-1.
- HOLD_CYCLES, 100000000: cycles btn_reset must stay debounced-pressed before clear_req fires; must be > DEBOUNCE_CYCLES.
- REPEAT_DELAY, 25000000: cycles a held up/down waits after its first pulse before auto-repeat starts.
- REPEAT_RATE, 10000000: cycles between successive auto-repeat pulses.
- CNT_W, 28: width of every internal counter; must hold the largest parameter value.

Ports:
- clk  in  1  board clock.
- reset  in  1  asynchronous, active-low. Low clears all state immediately.
- btn_up  in  1  raw pad, active-high, asynchronous.
- btn_down  in  1  raw pad, active-high, asynchronous.
- btn_change  in  1  raw pad, active-high, asynchronous.
- btn_reset  in  1  raw pad, active-high, asynchronous.
- up  out  1  one-clk pulse per accepted up press or repeat.
- down  out  1  one-clk pulse per accepted down press or repeat.
- change  out  1  view-select level; toggles once per accepted change press.
- clear_req  out  1  one-clk pulse after a qualified long press of btn_reset.
- any_held  out  1  high while any debounced button is pressed.

Behaviour:
- Reset (reset=0, async):
  - all outputs 0, including change=0 (time view);
  - sync flops, stable states, counters and FSMs cleared.
  - First edge after release behaves as idle.
- Synchroniser: each raw input passes through 2 flops; the second flop's output is the synced value.
- Debounce, per button:
  - Counter increments on every edge where synced != stable; it clears to 0 on any edge where they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, stable flips on that edge and the counter clears.
  - Latency: for a clean press with raw high before edge 1, stable rises at edge 2+DEBOUNCE_CYCLES.
  - Any glitch shorter than DEBOUNCE_CYCLES is rejected.
- Press and release events are derived from stable rising/falling. All outputs are registered.
  - up/down/clear_req pulses and the change toggle appear on the same edge that stable flips.
- up/down FSM, per key:
  - States: IDLE, FIRST, REPEAT.
  - IDLE -> FIRST on stable rise: emit a pulse and load the repeat counter.
  - FIRST -> REPEAT after REPEAT_DELAY cycles still held: emit a pulse.
  - REPEAT: emit a pulse every REPEAT_RATE cycles while held.
  - Any state -> IDLE on stable fall, with no pulse.
  - Simultaneous up and down both stable-high: both FSMs hold their current counter and emit no repeats. Initial pulses already emitted stand.
- change: toggles on stable rise only; release has no effect.
  - While btn_reset is debounced-pressed, change presses are ignored.
- Reset-key FSM:
  - States: R_IDLE, R_HOLD, R_DONE.
  - R_IDLE -> R_HOLD on stable rise; the hold counter starts at 0.
  - R_HOLD: when the counter reaches HOLD_CYCLES, emit clear_req and go to R_DONE.
  - R_HOLD -> R_IDLE on stable fall before that, with no pulse.
  - R_DONE -> R_IDLE on stable fall. Only one clear_req per press, however long it is held.
- clear_req also forces up/down FSMs to IDLE for the remainder of that press. It does not change the change level.
- Counters saturate, never wrap. any_held = OR of the four stable states.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined: the FIRST/REPEAT behaviour above.
- Undefined:
  - up/down emit exactly one pulse per press;
  - the FSM is reduced to IDLE/FIRST;
  - REPEAT_DELAY and REPEAT_RATE are unused;
  - the repeat counters are not synthesised.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, REPEAT_DELAY=20, REPEAT_RATE=8, AUTO_REPEAT_EN defined):
- Reset low mid-count with btn_up held 3 cycles -> all outputs 0 asynchronously; after release, no up pulse until a full 4-cycle stable window.
- btn_up high for 3 cycles then low (bounce) -> no up pulse. btn_up high for 10 cycles -> exactly one up pulse, high only after edge 6.
- btn_down held 60 cycles -> pulses at edges 6, 26, 34, 42, 50, 58; none after release.
- btn_change pressed and released twice -> change goes 0->1->0, toggling on each press edge.
- btn_reset held 30 cycles -> one clear_req at edge 22. Held only 12 cycles -> no clear_req.
- btn_up and btn_down pressed together and held 40 cycles -> one up and one down pulse at edge 6, then no repeats. Rebuild without AUTO_REPEAT_EN and hold btn_up 60 cycles -> exactly one up pulse.
